pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready handshake, flush and back-pressure, replacing the fixed 32+32-bit IF/ID latch. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque WIDTH-bit payload, so IF/ID packs {pc_plus_4, instruction} into one bus. It adds stall support, flush-to-bubble for branch/jump recovery, an optional skid slot for registered ready, and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 40 ++++
 rtl/pipe_slot.sv | 32 +++
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage payload layouts and widths.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic [3:0]  ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  dest;
    logic [1:0]  ctrl;
  } mem_wb_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t);
  localparam int EX_MEM_W = $bits(ex_mem_t);
  localparam int MEM_WB_W = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid+data holding register. clear beats load beats drop.
module pipe_slot #(
  parameter int              WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             drop,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot register: flush/reset return it to the bubble value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, flush and stall counter.
// Define PIPE_SKID_EN to add a skid slot (registered in_ready, capacity 2).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = IF_ID_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             in_fire, out_fire;
  logic             main_load, main_drop;
  logic [WIDTH-1:0] main_src;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .drop      (main_drop),
    .clear     (flush),
    .load_data (main_src),
    .valid     (out_valid),
    .data      (out_data)
  );

`ifdef PIPE_SKID_EN
  logic             skid_load, skid_drop, skid_valid;
  logic [WIDTH-1:0] skid_data;

  pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .drop      (skid_drop),
    .clear     (flush),
    .load_data (in_data),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  // in_ready is straight off the skid valid flop.
  assign in_ready = ~skid_valid;

  // Slot steering: a stalled main diverts the new beat to skid; skid drains first.
  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    main_src  = in_data;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    if (!out_valid) begin
      main_load = in_fire;
    end else if (out_ready) begin
      if (skid_valid) begin
        main_load = 1'b1;
        main_src  = skid_data;
        skid_drop = 1'b1;
      end else if (in_fire) begin
        main_load = 1'b1;
      end else begin
        main_drop = 1'b1;
      end
    end else begin
      skid_load = in_fire;
    end
  end
`else
  // Capacity 1: accept whenever the held beat leaves this cycle.
  assign in_ready = ~out_valid | out_ready;

  // Slot steering: a new beat replaces the old one, otherwise a consumed beat empties.
  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    main_src  = in_data;
    if (in_fire)       main_load = 1'b1;
    else if (out_fire) main_drop = 1'b1;
  end
`endif

  // Saturating stall counter; flush does not touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                               stall_cycles <= '0;
    else if (out_valid && !out_ready && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (either PIPE_SKID_EN build).
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [15:0] stall_cycles;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush;
  logic [7:0]  s_in_data, s_out_data;
  logic [3:0]  s_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .stall_cycles(stall_cycles)
  );

  pipe_stage_reg #(.WIDTH(8), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .flush(s_flush), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .stall_cycles(s_stall)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h0000_0004_2002_0005;
    s_in_valid = 1'b0; s_in_data = 8'hA5; s_out_ready = 1'b0; s_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || stall_cycles !== 16'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: valid=%b data=%h ready=%b stall=%0d, want 0/0/1/0",
                 i, out_valid, out_data, in_ready, stall_cycles);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h0000_0004_2002_0005) begin
      errors++;
      $display("FAIL first_beat: valid=%b data=%h, want 1/0000000420020005", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_after_first: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    in_valid = 1'b1; in_data = 64'hAAAA; out_ready = 1'b0;
    step();                              // A loaded, stall begins
    in_data = 64'hBBBB;                  // B offered during the stall
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'hAAAA || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: valid=%b data=%h ready=%b, want 1/aaaa/0",
                 i, out_valid, out_data, in_ready);
      end
    end
    checks++;
    if (stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL stall_count: got %0d want 5", stall_cycles);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
`ifdef PIPE_SKID_EN
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'hBBBB) begin
      errors++;
      $display("FAIL skid_order: valid=%b data=%h, want 1/bbbb", out_valid, out_data);
    end
    step();
`endif
    checks++;
    if (out_valid !== 1'b0 || stall_cycles !== 16'd5) begin
      errors++;
      $display("FAIL stall_release: valid=%b stall=%0d, want 0/5", out_valid, stall_cycles);
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = 64'hDDDD; out_ready = 1'b0;
    step();
    flush = 1'b1; in_data = 64'hCCCC;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b data=%h, want 0/0", out_valid, out_data);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data === 64'hCCCC) begin
      errors++;
      $display("FAIL flush_discard: valid=%b data=%h, want 0 and not cccc", out_valid, out_data);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 64'hEEEE;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_b2b cyc%0d: valid=%b want 0", i, out_valid);
      end
    end
    flush = 1'b0; in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 64'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 64'(i) || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b beat%0d: valid=%b data=%h ready=%b, want 1/%0h/1",
                 i, out_valid, out_data, in_ready, i);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    s_in_valid = 1'b1; s_out_ready = 1'b0;
    step();
    s_in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20) begin
        checks++;
        if (s_stall !== ((i < 15) ? 4'(i) : 4'd15)) begin
          errors++;
          $display("FAIL stall_sat after %0d: got %0d", i, s_stall);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1111;
    step();
    in_data = 64'h2222;
    step();
    in_valid = 1'b0;
    step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cycles !== 16'd0 || out_data !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b stall=%0d data=%h, want 0/1/0/0",
               out_valid, in_ready, stall_cycles, out_data);
    end
    #1 reset = 1'b0;
    in_valid = 1'b1; in_data = 64'h3333; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h3333) begin
      errors++;
      $display("FAIL post_reset_fire: valid=%b data=%h, want 1/3333", out_valid, out_data);
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
